uart_transmitter: RTL and testbench

Serial frame transmitter forming the sending end of the UART link. Accepts one byte per valid/ready handshake and shifts it out on a single serial line in the exact frame format the UART receiver decodes: start, 8 data bits LSB-first, even parity, two stop bits. It also drives a one-bit-time guard level between frames. It sits between the byte-producing logic and the serial pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_transmitter.sv | 122 ++++++++++++
 tb/tb_uart_transmitter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both ends of the link.
// Holds the frame geometry, the line levels and the transmitter state encoding.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam int   UART_STOP_BITS   = 2;

    localparam logic UART_IDLE_LEVEL  = 1'b0;
    localparam logic UART_START_LEVEL = 1'b1;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2,
        TX_GUARD
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and raises tick during the terminal count cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   restart    : synchronous restart, counter goes to 0 on the next edge
//   tick       : high during the last cycle of the current bit time
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART frame transmitter: start, 8 data bits LSB-first, even parity,
// two stop bits, then one guard bit time at idle level.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   tx_data    : byte to send, sampled on the valid/ready handshake
//   tx_valid   : tx_data holds a byte
//   tx_ready   : high only in IDLE
//   serial     : registered serial line
//   tx_busy    : frame or guard in progress (!tx_ready)
//   tx_done    : one-cycle pulse during the last cycle of the second stop bit
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           parity_q, parity_d;
    logic           serial_q, serial_d;
    logic           tick;
    logic           restart;

    // Every state entry starts a fresh bit time; IDLE holds the counter at 0
    // so the start bit is full length regardless of when the handshake lands.
    assign restart = (state_d != state_q) || (state_q == TX_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign tx_ready = (state_q == TX_IDLE);
    assign tx_busy  = !tx_ready;
    assign serial   = serial_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_done   = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    shreg_d   = tx_data;
                    parity_d  = ^tx_data;
                    bit_cnt_d = '0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (tick) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) state_d = TX_PARITY;
                end
            end
            TX_PARITY: begin
                if (tick) state_d = TX_STOP1;
            end
            TX_STOP1: begin
                if (tick) state_d = TX_STOP2;
            end
            TX_STOP2: begin
                if (tick) begin
                    tx_done = 1'b1;
                    state_d = TX_GUARD;
                end
            end
            TX_GUARD: begin
                if (tick) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level is computed from the next state so the register holds
        // the level of the bit that is current after this edge.
        case (state_d)
            TX_START:           serial_d = UART_START_LEVEL;
            TX_DATA:            serial_d = shreg_d[0];
            TX_PARITY:          serial_d = parity_d;
            TX_STOP1, TX_STOP2: serial_d = UART_STOP_LEVEL;
            default:            serial_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            serial_q  <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: one instance at CLKS_PER_BIT=1,
// one at CLKS_PER_BIT=4, compared against a frame-level reference model.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] tx_data1, tx_data4;
    logic       tx_valid1, tx_valid4;
    logic       tx_ready1, tx_ready4;
    logic       serial1, serial4;
    logic       tx_busy1, tx_busy4;
    logic       tx_done1, tx_done4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .serial(serial1), .tx_busy(tx_busy1), .tx_done(tx_done1)
    );

    uart_transmitter #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data4), .tx_valid(tx_valid4),
        .tx_ready(tx_ready4), .serial(serial4), .tx_busy(tx_busy4), .tx_done(tx_done4)
    );

    // Reference: level of frame bit idx (0=start .. 12=guard) for byte b.
    function automatic logic exp_level(input logic [7:0] b, input int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (idx == 0)                   return 1'b1;
        else if (idx >= 1 && idx <= 8)  return b[idx-1];
        else if (idx == 9)              return (ones % 2) == 1;
        else if (idx == 10 || idx == 11) return 1'b1;
        else                            return 1'b0;
    endfunction

    // Expected serial at cycles N+1 .. N+13*cpb+1 (bit k of the result).
    function automatic logic [63:0] exp_trace(input logic [7:0] b, input int cpb);
        logic [63:0] t;
        t = '0;
        for (int k = 1; k <= 13 * cpb; k++) t[k] = exp_level(b, (k - 1) / cpb);
        t[13 * cpb + 1] = 1'b0;
        return t;
    endfunction

    // Send one byte on the selected instance and record what it does for
    // 13*cpb+1 cycles after the handshake edge.
    task automatic send_capture(input int sel, input logic [7:0] b,
                                output logic [63:0] trace, output int done_at,
                                output int rdy_at, output int busy_cnt, output int done_cnt);
        int cpb;
        logic s, d, r, bz;
        cpb = (sel == 4) ? 4 : 1;
        trace = '0; done_at = 0; rdy_at = 0; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        if (sel == 4) begin tx_data4 = b; tx_valid4 = 1'b1; end
        else          begin tx_data1 = b; tx_valid1 = 1'b1; end
        @(posedge clk);
        #1;
        // Changing the input after the handshake must not reach the frame.
        if (sel == 4) begin tx_valid4 = 1'b0; tx_data4 = ~b; end
        else          begin tx_valid1 = 1'b0; tx_data1 = ~b; end
        for (int k = 1; k <= 13 * cpb + 1; k++) begin
            @(negedge clk);
            s  = (sel == 4) ? serial4   : serial1;
            d  = (sel == 4) ? tx_done4  : tx_done1;
            r  = (sel == 4) ? tx_ready4 : tx_ready1;
            bz = (sel == 4) ? tx_busy4  : tx_busy1;
            trace[k] = s;
            if (d) begin done_at = k; done_cnt++; end
            if (bz) busy_cnt++;
            if (r && rdy_at == 0) rdy_at = k;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_valid1 = 1'b0; tx_valid4 = 1'b0; tx_data1 = '0; tx_data4 = '0;
        #3;
        n_checks++;
        if ({serial1, tx_ready1, tx_busy1, tx_done1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_dut1 got serial/ready/busy/done=%b want 0100",
                     {serial1, tx_ready1, tx_busy1, tx_done1});
        end
        n_checks++;
        if ({serial4, tx_ready4, tx_busy4, tx_done4} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_dut4 got serial/ready/busy/done=%b want 0100",
                     {serial4, tx_ready4, tx_busy4, tx_done4});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (serial1 !== 1'b0 || tx_ready1 !== 1'b1 || tx_done1 !== 1'b0 || tx_busy1 !== 1'b0 ||
                serial4 !== 1'b0 || tx_ready4 !== 1'b1 || tx_done4 !== 1'b0 || tx_busy4 !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_20 got %0d bad idle cycles want 0", bad);
        end
    endtask

    task automatic test_known_bytes();
        logic [63:0] tr;
        int da, ra, bc, dc;
        logic [12:0] a5_frame;
        logic [7:0] rx_byte;
        logic par;
        // 0xA5: start..guard as listed from the line.
        a5_frame = 13'b1_1_0_1_0_0_1_0_1_0_1_1_0;
        send_capture(1, 8'hA5, tr, da, ra, bc, dc);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (tr[i+1] !== a5_frame[12-i]) begin
                n_fail++;
                $display("FAIL a5_bit%0d got %b want %b", i, tr[i+1], a5_frame[12-i]);
            end
        end
        n_checks++;
        if (da !== 12) begin n_fail++; $display("FAIL a5_done_cycle got %0d want 12", da); end
        n_checks++;
        if (ra !== 14) begin n_fail++; $display("FAIL a5_ready_cycle got %0d want 14", ra); end

        // 0x01 decoded the way the receiver samples it.
        send_capture(1, 8'h01, tr, da, ra, bc, dc);
        for (int i = 0; i < 8; i++) rx_byte[i] = tr[2+i];
        par = tr[10];
        n_checks++;
        if (rx_byte !== 8'h01) begin n_fail++; $display("FAIL x01_rx_byte got %h want 01", rx_byte); end
        n_checks++;
        if (par !== 1'b1) begin n_fail++; $display("FAIL x01_parity got %b want 1", par); end
        n_checks++;
        if ((^{rx_byte, par}) !== 1'b0) begin
            n_fail++; $display("FAIL x01_even_parity got odd ones count want even");
        end
    endtask

    task automatic test_random_frames();
        logic [63:0] tr, ex;
        int da, ra, bc, dc;
        logic [7:0] b;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            send_capture(1, b, tr, da, ra, bc, dc);
            ex = exp_trace(b, 1);
            n_checks++;
            if (tr !== ex) begin
                n_fail++; $display("FAIL rand1_trace byte=%h got %h want %h", b, tr, ex);
            end
            n_checks++;
            if (dc !== 1 || da !== 12) begin
                n_fail++; $display("FAIL rand1_done byte=%h got %0d pulses at %0d want 1 at 12", b, dc, da);
            end
        end
    endtask

    task automatic test_cpb4();
        logic [63:0] tr, ex;
        int da, ra, bc, dc;
        logic [7:0] b;
        for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'hFF : 8'($urandom);
            send_capture(4, b, tr, da, ra, bc, dc);
            ex = exp_trace(b, 4);
            n_checks++;
            if (tr !== ex) begin
                n_fail++; $display("FAIL cpb4_trace byte=%h got %h want %h", b, tr, ex);
            end
            n_checks++;
            if (bc !== 52) begin n_fail++; $display("FAIL cpb4_busy byte=%h got %0d want 52", b, bc); end
            n_checks++;
            if (dc !== 1 || da !== 48) begin
                n_fail++; $display("FAIL cpb4_done byte=%h got %0d pulses at %0d want 1 at 48", b, dc, da);
            end
            n_checks++;
            if (ra !== 53) begin n_fail++; $display("FAIL cpb4_ready byte=%h got %0d want 53", b, ra); end
        end
        // Parity bit of 0xFF sits in frame bit 9.
    endtask

    task automatic test_back_to_back();
        logic [63:0] tr, ex, e1, e2;
        int dc, hs;
        int d_at[2];
        tr = '0; dc = 0; hs = 0; d_at[0] = 0; d_at[1] = 0;
        e1 = exp_trace(8'h3C, 1);
        e2 = exp_trace(8'hC3, 1);
        ex = '0;
        for (int k = 1; k <= 13; k++) begin
            ex[k]      = e1[k];
            ex[k + 14] = e2[k];
        end
        @(negedge clk);
        tx_data1 = 8'h3C; tx_valid1 = 1'b1;
        @(posedge clk);
        #1 tx_data1 = 8'hC3;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            tr[k] = serial1;
            if (tx_done1) begin
                if (dc < 2) d_at[dc] = k;
                dc++;
            end
            if (tx_ready1 && tx_valid1) hs++;
            if (k == 14) begin
                @(posedge clk);
                #1 tx_valid1 = 1'b0; tx_data1 = 8'h00;
            end
            if (k == 20) tx_data1 = 8'($urandom);
        end
        n_checks++;
        if (tr !== ex) begin n_fail++; $display("FAIL b2b_trace got %h want %h", tr, ex); end
        n_checks++;
        if (dc !== 2 || d_at[0] !== 12 || d_at[1] !== 26) begin
            n_fail++;
            $display("FAIL b2b_done got %0d pulses at %0d,%0d want 2 at 12,26", dc, d_at[0], d_at[1]);
        end
        n_checks++;
        if (hs !== 1) begin n_fail++; $display("FAIL b2b_second_handshake got %0d want 1", hs); end
        n_checks++;
        if (tx_ready1 !== 1'b1) begin n_fail++; $display("FAIL b2b_end_ready got %b want 1", tx_ready1); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] tr, ex;
        int da, ra, bc, dc;
        logic [7:0] b;
        b = 8'($urandom);
        @(negedge clk);
        tx_data1 = b; tx_valid1 = 1'b1;
        @(posedge clk);
        #1 tx_valid1 = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (serial1 !== b[4]) begin
            n_fail++; $display("FAIL mid_d4_level got %b want %b", serial1, b[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({serial1, tx_ready1, tx_busy1, tx_done1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL mid_async_reset got serial/ready/busy/done=%b want 0100",
                     {serial1, tx_ready1, tx_busy1, tx_done1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_capture(1, 8'h5A, tr, da, ra, bc, dc);
        ex = exp_trace(8'h5A, 1);
        n_checks++;
        if (tr !== ex) begin n_fail++; $display("FAIL post_reset_5a got %h want %h", tr, ex); end
        n_checks++;
        if (dc !== 1 || ra !== 14) begin
            n_fail++; $display("FAIL post_reset_5a_ctl got done=%0d ready_at=%0d want 1,14", dc, ra);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_known_bytes();
        test_random_frames();
        test_cpb4();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
